// File: rtl/key_press_classifier_if.sv
// key_press_classifier_if: edge strobes from the key-pin edge detector into
// the classifier, and the classified key events back to the front-panel logic.
interface key_press_classifier_if;
    logic       h2l_edge;      // one-cycle press strobe (key is active-low)
    logic       l2h_edge;      // one-cycle release strobe
    logic       short_press;   // one-cycle pulse, committed short press
    logic       long_press;    // one-cycle pulse, hold reached the long time
    logic       repeat_press;  // one-cycle auto-repeat pulse
    logic       key_held;      // debounced pressed level
    logic [7:0] press_cnt;     // committed presses, wraps 255 -> 0

    // Strobe source / event consumer side.
    modport master (
        output h2l_edge,
        output l2h_edge,
        input  short_press,
        input  long_press,
        input  repeat_press,
        input  key_held,
        input  press_cnt
    );

    // Classifier side.
    modport slave (
        input  h2l_edge,
        input  l2h_edge,
        output short_press,
        output long_press,
        output repeat_press,
        output key_held,
        output press_cnt
    );
endinterface

// File: rtl/key_press_classifier.sv
// key_press_classifier: debounces key-pin edge strobes and classifies them
// into short press, long press and (optionally) auto-repeat events, with a
// debounced held level and a wrapping press counter. All outputs registered.
// Optional feature: define KEY_REPEAT_EN to build the auto-repeat generator;
// without it repeat_press is tied low and the hold counter parks in LONG_HELD.
module key_press_classifier #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    key_press_classifier_if.slave key_if
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_LONG_HELD,
        ST_RELEASE_DB
    } state_t;

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    // Every counter terminal value must fit in CNT_W bits; a repeat period of
    // one cycle would make repeat pulses back-to-back.
    if (CNT_W < 1 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 2 ||
        longint'(DEBOUNCE_CYC) >= CNT_LIMIT ||
        longint'(LONG_CYC) >= CNT_LIMIT ||
        longint'(REPEAT_CYC) >= CNT_LIMIT) begin : g_bad_params
        $error("key_press_classifier: counter parameters out of range");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

    state_t           state_q,       state_d;
    logic [CNT_W-1:0] db_cnt_q,      db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic             pend_long_q,   pend_long_d;
    logic             key_held_q,    key_held_d;
    logic             short_press_q, short_press_d;
    logic             long_press_q,  long_press_d;
    logic [7:0]       press_cnt_q,   press_cnt_d;
`ifdef KEY_REPEAT_EN
    logic             repeat_press_q, repeat_press_d;
    logic             repeat_done;
`endif

    // Strobes arriving together cancel each other in every state.
    logic press_stb;
    logic release_stb;
    logic db_done;
    logic long_done;

    assign press_stb   = key_if.h2l_edge & ~key_if.l2h_edge;
    assign release_stb = key_if.l2h_edge & ~key_if.h2l_edge;
    assign db_done     = (db_cnt_q == DB_LAST);
    assign long_done   = (hold_cnt_q == LONG_LAST);
`ifdef KEY_REPEAT_EN
    assign repeat_done = (hold_cnt_q == REPEAT_LAST);
`endif

    // Next-state, counter and event-pulse decode.
    always_comb begin
        // NOTE: every signal is given its hold/idle value first, so no branch
        // can leave one unassigned and infer a latch.
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        pend_long_d   = pend_long_q;
        key_held_d    = key_held_q;
        press_cnt_d   = press_cnt_q;
        short_press_d = 1'b0;
        long_press_d  = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_press_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (press_stb) begin
                    state_d  = ST_PRESS_DB;
                    db_cnt_d = '0;
                end
            end

            ST_PRESS_DB: begin
                db_cnt_d = db_cnt_q + 1'b1;
                // Reaching the terminal count wins over a same-cycle release.
                if (db_done) begin
                    state_d     = ST_HELD;
                    key_held_d  = 1'b1;
                    hold_cnt_d  = '0;
                    pend_long_d = 1'b0;
                end else if (release_stb) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HELD: begin
                if (long_done) begin
                    state_d      = ST_LONG_HELD;
                    long_press_d = 1'b1;
                    hold_cnt_d   = '0;
                    pend_long_d  = 1'b1;
                end else if (!release_stb) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // A release is never lost: it still opens the release
                // debounce even on the cycle the long press fires.
                if (release_stb) begin
                    state_d  = ST_RELEASE_DB;
                    db_cnt_d = '0;
                end
            end

            ST_LONG_HELD: begin
`ifdef KEY_REPEAT_EN
                if (repeat_done) begin
                    repeat_press_d = 1'b1;
                    hold_cnt_d     = '0;
                end else if (!release_stb) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
                if (release_stb) begin
                    state_d  = ST_RELEASE_DB;
                    db_cnt_d = '0;
                end
            end

            ST_RELEASE_DB: begin
                // hold_cnt stays frozen so a bounce resumes the hold timing.
                db_cnt_d = db_cnt_q + 1'b1;
                if (db_done) begin
                    state_d       = ST_IDLE;
                    key_held_d    = 1'b0;
                    press_cnt_d   = press_cnt_q + 8'd1;
                    short_press_d = ~pend_long_q;
                end else if (press_stb) begin
                    state_d = pend_long_q ? ST_LONG_HELD : ST_HELD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge.
        if (rst) begin
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            pend_long_q   <= 1'b0;
            key_held_q    <= 1'b0;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            press_cnt_q   <= 8'd0;
`ifdef KEY_REPEAT_EN
            repeat_press_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            pend_long_q   <= pend_long_d;
            key_held_q    <= key_held_d;
            short_press_q <= short_press_d;
            long_press_q  <= long_press_d;
            press_cnt_q   <= press_cnt_d;
`ifdef KEY_REPEAT_EN
            repeat_press_q <= repeat_press_d;
`endif
        end
    end

    assign key_if.short_press = short_press_q;
    assign key_if.long_press  = long_press_q;
    assign key_if.key_held    = key_held_q;
    assign key_if.press_cnt   = press_cnt_q;
`ifdef KEY_REPEAT_EN
    assign key_if.repeat_press = repeat_press_q;
`else
    assign key_if.repeat_press = 1'b0;
`endif

endmodule
